// File: rtl/home_pkg.sv
// Shared definitions for the home-automation event arbiter:
// source indices, display codes, FSM state encoding and decode helpers.
package home_pkg;

  localparam int unsigned NSRC = 6;

  localparam logic [2:0] SRC_FIRE  = 3'd0;
  localparam logic [2:0] SRC_FDOOR = 3'd1;
  localparam logic [2:0] SRC_RDOOR = 3'd2;
  localparam logic [2:0] SRC_WIN   = 3'd3;
  localparam logic [2:0] SRC_COLD  = 3'd4;
  localparam logic [2:0] SRC_HOT   = 3'd5;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_FDOOR = 3'd1;
  localparam logic [2:0] CODE_RDOOR = 3'd2;
  localparam logic [2:0] CODE_FIRE  = 3'd3;
  localparam logic [2:0] CODE_WIN   = 3'd4;
  localparam logic [2:0] CODE_COLD  = 3'd5;
  localparam logic [2:0] CODE_HOT   = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [2:0] disp_code(input logic [2:0] src);
    case (src)
      SRC_FIRE:  return CODE_FIRE;
      SRC_FDOOR: return CODE_FDOOR;
      SRC_RDOOR: return CODE_RDOOR;
      SRC_WIN:   return CODE_WIN;
      SRC_COLD:  return CODE_COLD;
      SRC_HOT:   return CODE_HOT;
      default:   return CODE_NONE;
    endcase
  endfunction

  function automatic logic [NSRC-1:0] src_onehot(input logic [2:0] src);
    logic [NSRC-1:0] v;
    v = '0;
    if (src < 3'(NSRC)) v[src] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/event_arbiter_if.sv
// Sensor inputs and annunciator/actuator outputs of the event arbiter.
interface event_arbiter_if;
  logic       SFD;
  logic       SRD;
  logic       SFA;
  logic       SW;
  logic [6:0] ST;
  logic       Ack;

  logic [2:0] display;
  logic       fdoor;
  logic       rdoor;
  logic       alarmbuzz;
  logic       winbuzz;
  logic       heater;
  logic       cooler;
  logic [5:0] pending;
  logic       busy;

  modport master (
    output SFD, SRD, SFA, SW, ST, Ack,
    input  display, fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler, pending, busy
  );

  modport slave (
    input  SFD, SRD, SFA, SW, ST, Ack,
    output display, fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler, pending, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Circular first-set search over sources 1..5, starting just after `last`.
module rr_pick
  import home_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last,
  output logic [2:0] grant,
  output logic       valid
);

  int unsigned pos;
  logic [2:0]  bit_idx;

  // req[0] is source 1; positions are source indices 1..5.
  always_comb begin
    grant   = SRC_FDOOR;
    valid   = 1'b0;
    pos     = 0;
    bit_idx = '0;
    for (int unsigned k = 1; k <= 5; k++) begin
      pos     = ({29'b0, last} + k - 1) % 5 + 1;
      bit_idx = 3'(pos - 1);
      if (!valid && req[bit_idx]) begin
        grant = 3'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_arbiter.sv
// Edge-captures sensor events and grants them one at a time to the shared
// annunciator: fire first, the rest round-robin, each held for HOLD cycles.
module event_arbiter
  import home_pkg::*;
#(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned LOW_T  = 50,
  parameter int unsigned HIGH_T = 70
) (
  input  logic            Clk,
  input  logic            Rst,
  event_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [6:0] LOW_LIM   = 7'(LOW_T);
  localparam logic [6:0] HIGH_LIM  = 7'(HIGH_T);

  arb_state_t      state;
  logic [NSRC-1:0] cond;
  logic [NSRC-1:0] cond_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] clr;
  logic [2:0]      gidx;
  logic [7:0]      cnt;
  logic [2:0]      last_rr;
  logic [2:0]      disp_q;
  logic [NSRC-1:0] act_q;
  logic            busy_q;

  logic [2:0]      rr_grant;
  logic            rr_valid;
  logic [2:0]      pick;
  logic            pick_ok;
  logic            release_now;

  always_comb begin
    cond            = '0;
    cond[SRC_FIRE]  = bus.SFA;
    cond[SRC_FDOOR] = bus.SFD;
    cond[SRC_RDOOR] = bus.SRD;
    cond[SRC_WIN]   = bus.SW;
    cond[SRC_COLD]  = (bus.ST < LOW_LIM);
    cond[SRC_HOT]   = (bus.ST > HIGH_LIM);
  end

  assign rise = cond & ~cond_q;

  rr_pick u_rr_pick (
    .req   (pending[NSRC-1:1]),
    .last  (last_rr),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  always_comb begin
    pick        = pending[SRC_FIRE] ? SRC_FIRE : rr_grant;
    pick_ok     = pending[SRC_FIRE] | rr_valid;
    release_now = (state == SERVE) && (cnt == '0) && (bus.Ack || !cond[gidx]);
    clr         = release_now ? src_onehot(gidx) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cond_q  <= '0;
      pending <= '0;
      gidx    <= SRC_FIRE;
      cnt     <= '0;
      last_rr <= SRC_HOT;
      disp_q  <= CODE_NONE;
      act_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      cond_q  <= cond;
      // A new edge on the source being released keeps its pending bit.
      pending <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            state  <= SERVE;
            gidx   <= pick;
            cnt    <= HOLD_LOAD;
            disp_q <= disp_code(pick);
            act_q  <= src_onehot(pick);
            busy_q <= 1'b1;
            if (pick != SRC_FIRE) last_rr <= pick;
          end
        end
        SERVE: begin
          if (release_now) begin
            state  <= GAP;
            disp_q <= CODE_NONE;
            act_q  <= '0;
            busy_q <= 1'b0;
          end else if (pending[SRC_FIRE] && (gidx != SRC_FIRE)) begin
            // Preempted source stays pending; last_rr is untouched.
            gidx   <= SRC_FIRE;
            cnt    <= HOLD_LOAD;
            disp_q <= disp_code(SRC_FIRE);
            act_q  <= src_onehot(SRC_FIRE);
          end else if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.display   = disp_q;
  assign bus.alarmbuzz = act_q[SRC_FIRE];
  assign bus.fdoor     = act_q[SRC_FDOOR];
  assign bus.rdoor     = act_q[SRC_RDOOR];
  assign bus.winbuzz   = act_q[SRC_WIN];
  assign bus.heater    = act_q[SRC_COLD];
  assign bus.cooler    = act_q[SRC_HOT];
  assign bus.pending   = pending;
  assign bus.busy      = busy_q;

endmodule

// File: doc/event_arbiter.md
# event_arbiter

Schedules home-automation sensor events onto the single shared annunciator: the 3-bit display plus one-hot actuator outputs (door indicators, buzzers, heater, cooler). Sensor events are edge-captured into a pending register so short pulses are not lost. Pending events are granted one at a time: fire alarm has fixed top priority, and the remaining sources share round-robin. Each grant is held for a minimum time and released by user acknowledge or by the condition clearing. Sits between the raw sensor inputs and the panel/actuator drivers.

## Interface
- HOLD, default 4: minimum cycles a grant is shown; legal range 1..255.
- LOW_T, default 50: heater request when ST < LOW_T.
- HIGH_T, default 70: cooler request when ST > HIGH_T; LOW_T ≤ HIGH_T is required.
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset Rst, synchronous, active-high.
- SFD, SRD, SFA, SW  in  1 each  front door, rear door, fire alarm, window sensors; level, active-high.
- ST  in  7  temperature, unsigned.
- Ack  in  1  user acknowledge of the currently shown event.
- display  out  3  code of the granted event; 0 when none.
- fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler  out  1 each  one-hot actuator for the granted event.
- pending  out  6  pending bits, index order below.
- busy  out  1  high while in SERVE.

## Operation
- Source index, condition and display code:
  - 0 fire: SFA, code 3, drives alarmbuzz.
  - 1 front door: SFD, code 1, drives fdoor.
  - 2 rear door: SRD, code 2, drives rdoor.
  - 3 window: SW, code 4, drives winbuzz.
  - 4 cold: ST<LOW_T, code 5, drives heater.
  - 5 hot: ST>HIGH_T, code 6, drives cooler.
- Capture: each condition is registered into cond_q. A rising edge (cond & ~cond_q) sets pending[i]. cond_q resets to 0, so a condition already true at reset release raises an event.
- States: IDLE, SERVE, GAP.
- IDLE, pending ≠ 0: pick index g.
  - Fire if pending[0].
  - Otherwise the first set bit among 1..5, searching circularly from last_rr+1. last_rr resets to 5, so the first search starts at 1.
  - Load hold counter with HOLD-1, enter SERVE, record g. last_rr←g for g≠0.
- SERVE: display and the single actuator for g are asserted; counter decrements to 0 and saturates there.
  - Release when counter==0 and (Ack or ~cond[g]): clear pending[g], enter GAP.
  - Ack while counter>0 is ignored, not stored.
- GAP: one cycle with display=0 and all actuators 0, then IDLE.
- Preemption: in SERVE with g≠0, pending[0] set → regrant to fire next cycle with a fresh hold count. pending[g] stays set, and the preempted source returns through round-robin later. last_rr is left unchanged by preemption.
- Simultaneous set and clear of the same pending bit: set wins.
- Ack in IDLE or GAP is ignored.
- Cold and hot are mutually exclusive by the parameter rule.
- Rst mid-SERVE: immediate return to IDLE; pending, cond_q and outputs are cleared.

## Timing
- Reset values: state IDLE, display 0, all actuators 0, pending 0, busy 0, cond_q 0, counter 0, last_rr 5.
- Outputs are registered.
- Condition rises before edge k → pending set after edge k → display/actuator valid after edge k+1 (2-cycle latency from IDLE).
- A grant lasts at least HOLD cycles. Release is sampled at the edge where counter==0; outputs drop at the next edge (GAP).
- Back-to-back grants are separated by exactly 2 dark cycles: GAP, then IDLE decision.
- Preemption: pending[0] visible at edge k → fire shown after edge k+1.

## Structure
- Shared package home_pkg holds:
  - source index constants (SRC_FIRE … SRC_HOT);
  - display code constants;
  - state encoding (IDLE, SERVE, GAP);
  - NSRC=6.
- Sub-module rr_pick: combinational. Inputs are a 5-bit request vector and a 3-bit last index; outputs are a grant index and a valid bit. Fire priority stays in the parent.
- The parent holds capture registers, pending, FSM, hold counter and the output decode.

## Test plan
- Reset then idle: Rst 2 cycles, all sensors 0, ST=60 → display 0, all outputs 0, pending 0 for 20 cycles.
- Single pulse: SFD high 1 cycle, no Ack → fdoor=1, display=1 from 2 cycles later. With SFD already low, release occurs at counter 0: shown exactly 4 cycles, then 2 dark cycles, pending 0.
- Round-robin: SFD, SRD, SW rise in the same cycle, each Ack'd as soon as allowed → codes 1, 2, 4 in order. Then SFD and SW rise again with last_rr=3 → code 4 first? No: the search from 4 wraps to 1, so code 1 is shown before code 4.
- Preemption: window being served (code 4), SFA rises → code 3 shown 2 cycles later. After Ack of fire, window code 4 is re-shown with a full HOLD.
- Temperature: ST 60→45 → heater=1, display=5. Then ST→75 while Ack is held low: the heater grant releases once the cold condition clears, then cooler=1, display=6.
- Early Ack and reset: Ack pulsed on the cycle of grant, SFA held high → grant persists past HOLD until Ack with counter 0. Rst asserted mid-SERVE → all outputs and pending 0 the next cycle.
